// File: rtl/csa_resolver_seq_if.sv
// Handshake and operand/result bus for csa_resolver_seq.
//   in_valid_i / in_ready_o      : operand-set handshake (upstream -> resolver)
//   Sum_i, Carry_i               : redundant compressor vectors, XLEN bits
//   hidden_carry_msb_i           : dropped top carry, weight 2^XLEN
//   out_valid_o / out_ready_i    : result handshake (resolver -> downstream)
//   Result_o                     : exact binary value, XLEN+2 bits
// master = operand source / result sink, slave = resolver.
interface csa_resolver_seq_if #(
    parameter int XLEN = 49
) ();
    localparam int W = XLEN + 2;

    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] Sum_i;
    logic [XLEN-1:0] Carry_i;
    logic            hidden_carry_msb_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [W-1:0]    Result_o;

    modport master (
        output in_valid_i, Sum_i, Carry_i, hidden_carry_msb_i, out_ready_i,
        input  in_ready_o, out_valid_o, Result_o
    );

    modport slave (
        input  in_valid_i, Sum_i, Carry_i, hidden_carry_msb_i, out_ready_i,
        output in_ready_o, out_valid_o, Result_o
    );
endinterface

// File: rtl/csa_resolver_seq.sv
// Sequential carry-propagate resolver for 4:2 compressor output.
// Accepts one (sum, carry, hidden-carry) set, adds it CHUNK bits per cycle
// with a registered inter-chunk carry and presents the exact W-bit result.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous, active-high reset
//   bus     : csa_resolver_seq_if.slave (operand/result handshake)
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready_o high
// BUSY  | resolving chunk k of NCHUNK
// DONE  | result valid, held until out_ready_i
module csa_resolver_seq #(
    parameter int XLEN  = 49,
    parameter int CHUNK = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    csa_resolver_seq_if.slave      bus
);
    localparam int W      = XLEN + 2;
    localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;
    localparam int WP     = NCHUNK * CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic [W-1:0]    r_q, r_d;
    logic [KW-1:0]   k_q, k_d;
    logic            c_q, c_d;

    logic [WP-1:0]   x_pad;
    logic [WP-1:0]   y_pad;
    logic [CHUNK:0]  chunk_sum;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        k_d     = k_q;
        c_d     = c_q;

        // Zero-extend to a whole number of chunks so the last, partial chunk
        // can use the same slice width as the others.
        x_pad          = '0;
        y_pad          = '0;
        x_pad[W-1:0]   = x_q;
        y_pad[W-1:0]   = y_q;
        chunk_sum      = {1'b0, x_pad[k_q*CHUNK +: CHUNK]}
                       + {1'b0, y_pad[k_q*CHUNK +: CHUNK]}
                       + (CHUNK+1)'(c_q);

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    x_d = {2'b00, bus.Sum_i};
                    // Carry MSB and the hidden carry share weight 2^XLEN;
                    // fold them into a 2-bit field so nothing is lost.
                    y_d = {bus.Carry_i[XLEN-1] & bus.hidden_carry_msb_i,
                           bus.Carry_i[XLEN-1] ^ bus.hidden_carry_msb_i,
                           bus.Carry_i[XLEN-2:0], 1'b0};
                    k_d     = '0;
                    c_d     = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Only bits below W are kept; padding bits of the last chunk drop.
                for (int i = 0; i < W; i++) begin
                    if ((i / CHUNK) == int'(k_q)) begin
                        r_d[i] = chunk_sum[i % CHUNK];
                    end
                end
                c_d = chunk_sum[CHUNK];
                if (k_q == KW'(NCHUNK - 1)) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            k_q     <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            k_q     <= k_d;
            c_q     <= c_d;
        end
    end

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.Result_o    = r_q;

endmodule
